dense_layer_seq: RTL

Parametrised fully-connected layer engine for the MNIST CNN classifier head: controller plus MAC datapath in one block.
- Buffers one input vector of IN_LEN signed fixed-point words.
- Computes OUT_LEN neurons as sum(w*x)+b against external synchronous weight/bias ROMs, with optional ReLU and saturation.
- Streams the results out over a valid/ready handshake.
- Successor to the fixed-size dense controller: generic sizes, streaming handshakes, saturation reporting and back-pressure.

---
 rtl/dense_layer_seq_pkg.sv | 48 ++++
 rtl/dense_layer_seq_if.sv | 36 +++
 rtl/dense_layer_seq_mac_unit.sv | 51 +++++
 rtl/dense_layer_seq.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/dense_layer_seq_pkg.sv
// Shared types and fixed-point helpers for the dense layer engine and its
// sibling convolution blocks.
package dense_layer_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_BIAS,
        ST_OUT
    } state_e;

    // Widest intermediate handled by the shared shift/saturate helper.
    localparam int SAT_W = 64;

    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic signed [SAT_W-1:0] q_max_pos(input int data_w);
        return (64'sd1 <<< (data_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [SAT_W-1:0] q_max_neg(input int data_w);
        return -(64'sd1 <<< (data_w - 1));
    endfunction

    // Floor-shift out the fractional bits, then clamp to a data_w-bit signed range.
    function automatic logic signed [SAT_W-1:0] sat_shift(
        input  logic signed [SAT_W-1:0] v,
        input  int                      frac_w,
        input  int                      data_w,
        output logic                    sat
    );
        logic signed [SAT_W-1:0] s;
        s   = v >>> frac_w;
        sat = 1'b0;
        if (s > q_max_pos(data_w)) begin
            s   = q_max_pos(data_w);
            sat = 1'b1;
        end else if (s < q_max_neg(data_w)) begin
            s   = q_max_neg(data_w);
            sat = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/dense_layer_seq_if.sv
// Stream, ROM and status signals of the dense layer engine.
interface dense_layer_seq_if
    import dense_layer_seq_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int IN_LEN  = 64,
    parameter int OUT_LEN = 10
);
    localparam int WAW = addr_w(IN_LEN * OUT_LEN);
    localparam int BAW = addr_w(OUT_LEN);

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_ready;
    logic [WAW-1:0]           w_addr;
    logic signed [DATA_W-1:0] w_data;
    logic [BAW-1:0]           b_addr;
    logic signed [DATA_W-1:0] b_data;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_last;
    logic                     out_ready;
    logic                     busy;
    logic                     sat_flag;

    modport slave (
        input  in_valid, in_data, w_data, b_data, out_ready,
        output in_ready, w_addr, b_addr, out_valid, out_data, out_last, busy, sat_flag
    );

    modport master (
        output in_valid, in_data, w_data, b_data, out_ready,
        input  in_ready, w_addr, b_addr, out_valid, out_data, out_last, busy, sat_flag
    );

endinterface

// File: rtl/dense_layer_seq_mac_unit.sv
// Multiply-accumulate datapath: one product per cycle, then bias, shift,
// saturate and optional ReLU on the finishing cycle.
module dense_mac_unit
    import dense_layer_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40,
    parameter int RELU   = 1
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     add_en,
    input  logic signed [DATA_W-1:0] x_p1,
    input  logic signed [DATA_W-1:0] w_p1,
    input  logic signed [DATA_W-1:0] b_p1,
    output logic signed [DATA_W-1:0] result,
    output logic                     sat
);
    logic signed [2*DATA_W-1:0] prod_p1;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    bias_al;
    logic signed [ACC_W-1:0]    fin_sum;
    logic signed [SAT_W-1:0]    shifted;

    always_comb begin
        prod_p1 = (2*DATA_W)'(x_p1) * (2*DATA_W)'(w_p1);
        bias_al = ACC_W'(b_p1) <<< FRAC_W;

        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (add_en) begin
            acc_d = acc_q + ACC_W'(prod_p1);
        end

        // The last product is still in flight when the bias arrives, so fold both in here.
        fin_sum = acc_q + ACC_W'(prod_p1) + bias_al;
        shifted = sat_shift(SAT_W'(fin_sum), FRAC_W, DATA_W, sat);
        if (RELU != 0 && shifted < 0) begin
            shifted = '0;
        end
        result = DATA_W'(shifted);
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

endmodule

// File: rtl/dense_layer_seq.sv
// Fully-connected layer engine: buffers one input vector, runs every neuron
// through the MAC unit against external weight/bias ROMs, streams results out.
module dense_layer_seq
    import dense_layer_seq_pkg::*;
#(
    parameter int IN_LEN  = 64,
    parameter int OUT_LEN = 10,
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int ACC_W   = 40,
    parameter int RELU    = 1
) (
    input  logic                clk,
    input  logic                rst,
    dense_layer_seq_if.slave    bus
);
    localparam int IW  = addr_w(IN_LEN);
    localparam int OW  = addr_w(OUT_LEN);
    localparam int WAW = addr_w(IN_LEN * OUT_LEN);
    localparam logic [IW-1:0] I_LAST = IW'(IN_LEN - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUT_LEN - 1);

    state_e                   state_q, state_d;
    logic [IW-1:0]            i_q, i_d;
    logic [IW-1:0]            i_p1_q, i_p1_d;
    logic [OW-1:0]            o_q, o_d;
    logic                     vld_p1_q, vld_p1_d;
    logic                     sat_q, sat_d;
    logic signed [DATA_W-1:0] in_buf_q  [IN_LEN];
    logic signed [DATA_W-1:0] in_buf_d  [IN_LEN];
    logic signed [DATA_W-1:0] out_buf_q [OUT_LEN];
    logic signed [DATA_W-1:0] out_buf_d [OUT_LEN];
    logic signed [DATA_W-1:0] mac_result;
    logic                     mac_sat;
    logic                     mac_clr;
    logic                     in_fire;
    logic [IW-1:0]            in_idx;

    assign in_fire = bus.in_valid && (state_q == ST_IDLE || state_q == ST_LOAD);
    assign in_idx  = (state_q == ST_IDLE) ? '0 : i_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            i_q      <= '0;
            o_q      <= '0;
            i_p1_q   <= '0;
            vld_p1_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            o_q      <= o_d;
            i_p1_q   <= i_p1_d;
            vld_p1_q <= vld_p1_d;
            sat_q    <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid) state_d = ST_LOAD;
            ST_LOAD: if (bus.in_valid && i_q == I_LAST) state_d = ST_MAC;
            ST_MAC:  if (i_q == I_LAST) state_d = ST_BIAS;
            ST_BIAS: state_d = (o_q == O_LAST) ? ST_OUT : ST_MAC;
            ST_OUT:  if (bus.out_ready && o_q == O_LAST) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
        bus.busy      = (state_q != ST_IDLE);
        bus.out_valid = (state_q == ST_OUT);
        bus.out_data  = (state_q == ST_OUT) ? out_buf_q[o_q] : '0;
        bus.out_last  = (state_q == ST_OUT) && (o_q == O_LAST);
        bus.w_addr    = '0;
        if (state_q == ST_MAC) begin
            bus.w_addr = WAW'(o_q) * WAW'(IN_LEN) + WAW'(i_q);
        end
        bus.b_addr    = (state_q == ST_MAC || state_q == ST_BIAS) ? o_q : '0;
        bus.sat_flag  = sat_q;
        mac_clr       = (state_q == ST_MAC) && (i_q == '0);
    end

    always_comb begin
        i_d      = i_q;
        o_d      = o_q;
        sat_d    = sat_q;
        i_p1_d   = i_q;
        vld_p1_d = (state_q == ST_MAC);
        case (state_q)
            ST_IDLE: begin
                o_d = '0;
                if (bus.in_valid) begin
                    i_d   = IW'(1);
                    sat_d = 1'b0;
                end
            end
            ST_LOAD: if (bus.in_valid) i_d = (i_q == I_LAST) ? '0 : i_q + IW'(1);
            ST_MAC:  i_d = (i_q == I_LAST) ? '0 : i_q + IW'(1);
            ST_BIAS: begin
                o_d = (o_q == O_LAST) ? '0 : o_q + OW'(1);
                if (mac_sat) sat_d = 1'b1;
            end
            ST_OUT:  if (bus.out_ready) o_d = (o_q == O_LAST) ? '0 : o_q + OW'(1);
            default: ;
        endcase
    end

    always_comb begin
        in_buf_d  = in_buf_q;
        out_buf_d = out_buf_q;
        if (in_fire) begin
            in_buf_d[in_idx] = bus.in_data;
        end
        if (state_q == ST_BIAS) begin
            out_buf_d[o_q] = mac_result;
        end
    end

    always_ff @(posedge clk) begin
        in_buf_q  <= in_buf_d;
        out_buf_q <= out_buf_d;
    end

    // ---- stage p1: ROM data and delayed index line up with the product ----
    dense_mac_unit #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W),
        .RELU   (RELU)
    ) u_mac (
        .clk    (clk),
        .clr    (mac_clr),
        .add_en (vld_p1_q),
        .x_p1   (in_buf_q[i_p1_q]),
        .w_p1   (bus.w_data),
        .b_p1   (bus.b_data),
        .result (mac_result),
        .sat    (mac_sat)
    );

endmodule
